// File: rtl/imm_extend_arbiter_pkg.sv
// rtl/imm_extend_arbiter_pkg.sv - shared extension-mode constants and slot types
package ext_defs;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;
  localparam int MODE_W = 2;

  // Extension modes selected per request.
  typedef enum logic [MODE_W-1:0] {
    EXT_SEXT = 2'b00,  // sign-extend
    EXT_ZEXT = 2'b01,  // zero-extend
    EXT_LUI  = 2'b10,  // immediate into upper half
    EXT_BOFS = 2'b11   // sign-extended branch offset, word-aligned (<<2)
  } ext_mode_e;

  // Output slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// rtl/imm_extend_core.sv - combinational 16->32 immediate extension datapath
module imm_extend_core
  import ext_defs::*;
(
  input  logic [IMM_W-1:0]  data_in,
  input  logic [MODE_W-1:0] mode,
  output logic [WORD_W-1:0] data_out
);

  // Select one of the four extension forms of the immediate.
  always_comb begin
    data_out = '0;
    unique case (ext_mode_e'(mode))
      EXT_SEXT: data_out = {{16{data_in[15]}}, data_in};
      EXT_ZEXT: data_out = {16'h0000, data_in};
      EXT_LUI:  data_out = {data_in, 16'h0000};
      EXT_BOFS: data_out = {{14{data_in[15]}}, data_in, 2'b00};
      default:  data_out = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_arbiter.sv
// rtl/imm_extend_arbiter.sv - round-robin shared immediate extender with one output slot
module imm_extend_arbiter
  import ext_defs::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [IMM_W*NUM_REQ-1:0]    req_data,
  input  logic [MODE_W*NUM_REQ-1:0]   req_mode,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WORD_W-1:0]           rsp_data,
  output logic [ID_W-1:0]             rsp_id
);

  slot_state_e        state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WORD_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic [IMM_W-1:0]   sel_data;
  logic [MODE_W-1:0]  sel_mode;
  logic [WORD_W-1:0]  ext_out;
  logic               can_accept;
  logic               accept;

  // Round-robin pick: first valid at or above ptr, else lowest valid (wrap-around).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel_data    = '0;
    sel_mode    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(i);
        sel_data    = req_data[i*IMM_W +: IMM_W];
        sel_mode    = req_mode[i*MODE_W +: MODE_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid[i]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(i);
        sel_data    = req_data[i*IMM_W +: IMM_W];
        sel_mode    = req_mode[i*MODE_W +: MODE_W];
      end
    end
  end

  imm_extend_core u_core (
    .data_in  (sel_data),
    .mode     (sel_mode),
    .data_out (ext_out)
  );

  // Slot can take a new result when empty or being drained this cycle; nothing while in reset.
  always_comb begin
    can_accept = ((state_q == SLOT_EMPTY) || rsp_ready) && !rst;
    accept     = can_accept && grant_valid;
  end

  // One-hot ready to the granted requester only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == ID_W'(i));
    end
  end

  // Slot FSM, result capture and pointer advance.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (accept) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (rsp_ready && !accept) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      rsp_data_d = ext_out;
      rsp_id_d   = grant_idx;
      ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // State registers with asynchronous reset that discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
